// File: rtl/decoder_scan_pkg.sv
// Shared constants for the decoder/scan block: mode encodings and default geometry.
// No latency or backpressure concerns: definitions only.
package decoder_scan_pkg;

    localparam int SEL_W_DEF = 3;
    localparam int DIV_DEF   = 4;

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

endpackage

// File: rtl/onehot_dec.sv
// One-hot decode of an index, forced to zero when disabled.
// Purely combinational, no backpressure.
module onehot_dec #(
    parameter  int SEL_W = 3,
    localparam int OUT_W = 2**SEL_W
) (
    input  logic [SEL_W-1:0] idx,
    input  logic             en,
    output logic [OUT_W-1:0] z
);

    assign z = en ? (OUT_W'(1) << idx) : '0;

endmodule

// File: rtl/decoder_scan.sv
// One-hot decoder with direct select or prescaled auto-scan; z/idx/wrap are registered (1 cycle).
// No backpressure: en freezes state and blanks z one cycle later.
module decoder_scan
    import decoder_scan_pkg::*;
#(
    parameter  int SEL_W = SEL_W_DEF,
    parameter  int DIV   = DIV_DEF,
    localparam int OUT_W = 2**SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             dir,
    input  logic [SEL_W-1:0] sel,
    input  logic             load,
    output logic [OUT_W-1:0] z,
    output logic [SEL_W-1:0] idx,
    output logic             wrap
);

    localparam int               CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
    localparam logic [SEL_W-1:0] IDX_MAX = SEL_W'(OUT_W - 1);

    logic [SEL_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             en_q, en_d;
    logic             wrap_q, wrap_d;

    always_comb begin
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        en_d   = en;
        wrap_d = 1'b0;
        if (en) begin
            if (mode == MODE_DIRECT || load) begin
                idx_d = sel;
                cnt_d = '0;
            end else if (cnt_q == CNT_MAX) begin
                // Index width is exactly log2(OUT_W), so +/-1 wraps modulo OUT_W for free.
                cnt_d = '0;
                if (dir) begin
                    idx_d  = idx_q + SEL_W'(1);
                    wrap_d = (idx_q == IDX_MAX);
                end else begin
                    idx_d  = idx_q - SEL_W'(1);
                    wrap_d = (idx_q == '0);
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= '0;
            cnt_q  <= '0;
            en_q   <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            en_q   <= en_d;
            wrap_q <= wrap_d;
        end
    end

    onehot_dec #(.SEL_W(SEL_W)) u_dec (
        .idx (idx_q),
        .en  (en_q),
        .z   (z)
    );

    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Directed bench: default-size instance plus a SEL_W=2, DIV=1 instance sharing the controls.
module tb_decoder_scan;

    logic       clk;
    logic       rst, en, mode, dir, load;
    logic [2:0] sel;
    logic [7:0] z1;
    logic [2:0] idx1;
    logic       wrap1;
    logic [3:0] z2;
    logic [1:0] idx2;
    logic       wrap2;

    int errors = 0;
    int checks = 0;

    decoder_scan dut1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir),
        .sel(sel), .load(load), .z(z1), .idx(idx1), .wrap(wrap1)
    );

    decoder_scan #(.SEL_W(2), .DIV(1)) dut2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir),
        .sel(sel[1:0]), .load(load), .z(z2), .idx(idx2), .wrap(wrap2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] e;

        // Reset state
        rst = 1'b1; en = 1'b0; mode = 1'b0; dir = 1'b1; sel = 3'd0; load = 1'b0;
        step();
        chk("rst_idx", {5'd0, idx1}, 8'h00);
        chk("rst_z", z1, 8'h00);
        chk("rst_wrap", {7'd0, wrap1}, 8'h00);

        // DIRECT sweep: z follows sel one cycle later
        rst = 1'b0; en = 1'b1; mode = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i);
            step();
            e = 8'd1 << i;
            chk($sformatf("direct_z%0d", i), z1, e);
            chk($sformatf("direct_wrap%0d", i), {7'd0, wrap1}, 8'h00);
        end

        // SCAN up from reset: step every 4 cycles, wrap after 7 -> 0
        rst = 1'b1;
        step();
        rst = 1'b0; mode = 1'b1; dir = 1'b1; load = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            step();
            e = 8'((k / 4) % 8);
            chk($sformatf("up_idx%0d", k), {5'd0, idx1}, e);
            chk($sformatf("up_z%0d", k), z1, 8'd1 << e);
            chk($sformatf("up_wrap%0d", k), {7'd0, wrap1}, (k == 32) ? 8'h01 : 8'h00);
        end

        // Advance to idx=3, cnt=2, then freeze for 5 cycles
        for (int k = 0; k < 14; k++) step();
        chk("pre_freeze_idx", {5'd0, idx1}, 8'h03);
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("freeze_z%0d", k), z1, 8'h00);
            chk($sformatf("freeze_idx%0d", k), {5'd0, idx1}, 8'h03);
        end
        en = 1'b1;
        step();
        chk("resume1_idx", {5'd0, idx1}, 8'h03);
        chk("resume1_z", z1, 8'h08);
        step();
        chk("resume2_idx", {5'd0, idx1}, 8'h04);

        // SCAN down after loading 2: 2,1,0,7 with wrap at 0 -> 7
        load = 1'b1; sel = 3'd2; dir = 1'b0;
        step();
        chk("load_idx", {5'd0, idx1}, 8'h02);
        chk("load_wrap", {7'd0, wrap1}, 8'h00);
        load = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("down_idx1", {5'd0, idx1}, 8'h01);
        for (int k = 0; k < 4; k++) step();
        chk("down_idx0", {5'd0, idx1}, 8'h00);
        chk("down_nowrap", {7'd0, wrap1}, 8'h00);
        for (int k = 0; k < 4; k++) step();
        chk("down_idx7", {5'd0, idx1}, 8'h07);
        chk("down_wrap", {7'd0, wrap1}, 8'h01);
        chk("down_z", z1, 8'h80);
        step();
        chk("down_wrap_end", {7'd0, wrap1}, 8'h00);

        // Reset mid-scan at idx=6
        for (int k = 0; k < 3; k++) step();
        chk("pre_rst_idx", {5'd0, idx1}, 8'h06);
        rst = 1'b1;
        step();
        chk("midrst_idx", {5'd0, idx1}, 8'h00);
        chk("midrst_z", z1, 8'h00);
        chk("midrst_wrap", {7'd0, wrap1}, 8'h00);

        // Load wins over a due step
        rst = 1'b0; dir = 1'b1;
        for (int k = 0; k < 3; k++) step();
        chk("pre_load_idx", {5'd0, idx1}, 8'h00);
        load = 1'b1; sel = 3'd5;
        step();
        chk("load_prio_idx", {5'd0, idx1}, 8'h05);
        chk("load_prio_z", z1, 8'h20);

        // Direction change mid-count keeps cnt progress
        load = 1'b0;
        step(); step();
        dir = 1'b0;
        step();
        chk("dirchg_hold", {5'd0, idx1}, 8'h05);
        step();
        chk("dirchg_idx", {5'd0, idx1}, 8'h04);

        // SEL_W=2, DIV=1 instance: steps every cycle
        rst = 1'b1;
        step();
        chk("small_rst_z", {4'd0, z2}, 8'h00);
        rst = 1'b0; en = 1'b1; mode = 1'b1; dir = 1'b1; load = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            e = 8'(k % 4);
            chk($sformatf("small_idx%0d", k), {6'd0, idx2}, e);
            chk($sformatf("small_z%0d", k), {4'd0, z2}, 8'd1 << e);
            chk($sformatf("small_wrap%0d", k), {7'd0, wrap2}, (k % 4 == 0) ? 8'h01 : 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
